// File: rtl/multicycle_right_shifter_if.sv
// Handshake bundle for multicycle_right_shifter: request channel (up_*) and result channel (down_*).
// slave is the shifter's view, master is the producer/consumer view.
interface multicycle_right_shifter_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          up_vld;
  logic          up_rdy;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_arith;
  logic          down_vld;
  logic          down_rdy;
  logic [N-1:0]  down_data;

  modport slave (
    input  up_vld, up_data, up_shamt, up_arith, down_rdy,
    output up_rdy, down_vld, down_data
  );

  modport master (
    output up_vld, up_data, up_shamt, up_arith, down_rdy,
    input  up_rdy, down_vld, down_data
  );
endinterface

// File: rtl/multicycle_right_shifter.sv
// Right shifter that moves one bit position per clock (logical or arithmetic fill).
// Define MULTICYCLE_RIGHT_SHIFTER_NIBBLE_STEP_EN to shift four positions per clock while at least four remain.
module multicycle_right_shifter #(
  parameter int N = 8
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_right_shifter_if.slave bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          fill_q, fill_d;
  logic          upRdy;
  logic          accept;
  logic [N-1:0]  step1;
  logic [N-1:0]  step4;

  assign upRdy         = !rst && (state_q == IDLE || (state_q == DONE && bus.down_rdy));
  assign accept        = bus.up_vld && upRdy;
  assign bus.up_rdy    = upRdy;
  assign bus.down_vld  = (state_q == DONE);
  assign bus.down_data = data_q;

  // The counter only ever counts down to zero, so amounts >= N simply keep shifting in fill bits.
  assign step1 = {fill_q, data_q[N-1:1]};
  assign step4 = (data_q >> 4) | (fill_q ? ~({N{1'b1}} >> 4) : '0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      SHIFT: begin
`ifdef MULTICYCLE_RIGHT_SHIFTER_NIBBLE_STEP_EN
        if (int'(cnt_q) >= 4) begin
          data_d = step4;
          cnt_d  = SW'(int'(cnt_q) - 4);
        end else begin
          data_d = step1;
          cnt_d  = cnt_q - SW'(1);
        end
        if (cnt_d == '0) state_d = DONE;
`else
        data_d = step1;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
`endif
      end
      DONE: begin
        if (bus.down_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new request can land in IDLE or on the same edge a finished result is taken.
    if (accept) begin
      data_d  = bus.up_data;
      cnt_d   = bus.up_shamt;
      fill_d  = bus.up_arith & bus.up_data[N-1];
      state_d = (bus.up_shamt == '0) ? DONE : SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end
endmodule

// File: tb/tb_multicycle_right_shifter.sv
// Directed and random checks of multicycle_right_shifter (N=8) against >> / >>> and the latency formula.
// Expected latency follows MULTICYCLE_RIGHT_SHIFTER_NIBBLE_STEP_EN when it is defined for the build.
module tb_multicycle_right_shifter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  multicycle_right_shifter_if #(.N(N)) bus ();

  multicycle_right_shifter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] k, input logic a);
    logic signed [7:0] s;
    s = d;
    return a ? 8'(s >>> k) : (d >> k);
  endfunction

  function automatic int expLat(input int k);
`ifdef MULTICYCLE_RIGHT_SHIFTER_NIBBLE_STEP_EN
    return 1 + k / 4 + k % 4;
`else
    return 1 + k;
`endif
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] k, input logic a);
    bus.up_vld   = 1'b1;
    bus.up_data  = d;
    bus.up_shamt = k;
    bus.up_arith = a;
  endtask

  // Present a request, wait for acceptance, then scramble the inputs to prove they are ignored.
  task automatic startOp(input string tag, input logic [7:0] d, input logic [2:0] k, input logic a);
    int guard;
    applyStimulus(d, k, a);
    bus.down_rdy = 1'b0;
    #1;
    guard = 0;
    while (!bus.up_rdy && guard < 20) begin
      cycle();
      guard++;
    end
    checkOutput({tag, " accept timeout"}, 32'(guard < 20), 32'd1);
    cycle();
    bus.up_vld   = 1'b0;
    bus.up_data  = ~d;
    bus.up_shamt = k + 3'd1;
    bus.up_arith = ~a;
  endtask

  // Called in the cycle after the accept edge; measures latency, stalls, then releases the result.
  task automatic finishOp(input string tag, input logic [7:0] expData, input int k, input int stall);
    int lat;
    lat = 1;
    while (!bus.down_vld && lat < 40) begin
      checkOutput({tag, " up_rdy busy"}, 32'(bus.up_rdy), 32'd0);
      cycle();
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat(k)));
    checkOutput({tag, " data"}, 32'(bus.down_data), 32'(expData));
    repeat (stall) begin
      cycle();
      checkOutput({tag, " stall vld"}, 32'(bus.down_vld), 32'd1);
      checkOutput({tag, " stall data"}, 32'(bus.down_data), 32'(expData));
      checkOutput({tag, " stall up_rdy"}, 32'(bus.up_rdy), 32'd0);
    end
    bus.down_rdy = 1'b1;
    cycle();
    bus.down_rdy = 1'b0;
    checkOutput({tag, " vld drop"}, 32'(bus.down_vld), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [7:0] d, input logic [2:0] k, input logic a, input int stall);
    startOp(tag, d, k, a);
    finishOp(tag, model(d, k, a), int'(k), stall);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] rk;
    logic       ra;
    int         quietBad;

    rst          = 1'b1;
    bus.up_vld   = 1'b0;
    bus.up_data  = '0;
    bus.up_shamt = '0;
    bus.up_arith = 1'b0;
    bus.down_rdy = 1'b0;
    #1;
    checkOutput("up_rdy in reset", 32'(bus.up_rdy), 32'd0);
    cycle();
    cycle();
    checkOutput("reset down_vld", 32'(bus.down_vld), 32'd0);
    checkOutput("reset down_data", 32'(bus.down_data), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("up_rdy idle", 32'(bus.up_rdy), 32'd1);

    runOp("logical k3", 8'b1011_0110, 3'd3, 1'b0, 0);
    checkOutput("model logical k3", 32'(model(8'b1011_0110, 3'd3, 1'b0)), 32'h16);
    runOp("arith k3", 8'b1011_0110, 3'd3, 1'b1, 1);
    checkOutput("model arith k3", 32'(model(8'b1011_0110, 3'd3, 1'b1)), 32'hF6);
    runOp("arith k7 pos", 8'b0111_0000, 3'd7, 1'b1, 0);
    runOp("arith k7 neg", 8'h80, 3'd7, 1'b1, 0);
    runOp("shamt0", 8'hA5, 3'd0, 1'b1, 0);
    runOp("k4", 8'hC3, 3'd4, 1'b1, 0);
    runOp("k5 logical", 8'hFF, 3'd5, 1'b0, 2);

    // Back-pressure for five cycles, then a new request taken on the releasing edge.
    startOp("bp", 8'b1011_0110, 3'd3, 1'b0);
    begin
      int lat;
      lat = 1;
      while (!bus.down_vld && lat < 40) begin
        cycle();
        lat++;
      end
      checkOutput("bp latency", 32'(lat), 32'(expLat(3)));
    end
    repeat (5) begin
      cycle();
      checkOutput("bp hold vld", 32'(bus.down_vld), 32'd1);
      checkOutput("bp hold data", 32'(bus.down_data), 32'h16);
      checkOutput("bp hold up_rdy", 32'(bus.up_rdy), 32'd0);
    end
    applyStimulus(8'h81, 3'd2, 1'b1);
    bus.down_rdy = 1'b1;
    #1;
    checkOutput("b2b up_rdy", 32'(bus.up_rdy), 32'd1);
    cycle();
    bus.down_rdy = 1'b0;
    bus.up_vld   = 1'b0;
    bus.up_data  = 8'h00;
    checkOutput("b2b vld drop", 32'(bus.down_vld), 32'd0);
    finishOp("b2b", 8'hE0, 2, 0);

    // Reset two cycles into a long shift discards the result.
    startOp("rst mid", 8'h5A, 3'd6, 1'b0);
    cycle();
    rst = 1'b1;
    #1;
    checkOutput("rst mid up_rdy", 32'(bus.up_rdy), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    checkOutput("rst mid vld", 32'(bus.down_vld), 32'd0);
    checkOutput("rst mid data", 32'(bus.down_data), 32'd0);
    checkOutput("rst mid idle", 32'(bus.up_rdy), 32'd1);
    quietBad = 0;
    repeat (10) begin
      cycle();
      if (bus.down_vld) quietBad++;
    end
    checkOutput("rst no result", 32'(quietBad), 32'd0);
    runOp("after rst", 8'h5A, 3'd6, 1'b1, 0);
    runOp("after rst neg", 8'hA5, 3'd6, 1'b1, 0);

    for (int i = 0; i < 1000; i++) begin
      rd = 8'($urandom);
      rk = 3'($urandom_range(0, 7));
      ra = 1'($urandom);
      runOp("random", rd, rk, ra, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
